// File: rtl/hangman_guess_engine_if.sv
// rtl/hangman_guess_engine_if.sv - game-control and display-status bundle for the hangman guess engine
interface hangman_guess_engine_if #(
    parameter int WORD_LEN = 5,
    parameter int LETTER_W = 5,
    parameter int MISS_W   = 3
);
    localparam int LEN_W = $clog2(WORD_LEN + 1);

    logic                         start;
    logic [WORD_LEN*LETTER_W-1:0] word;
    logic [LEN_W-1:0]             word_len;
    logic                         go;
    logic [LETTER_W-1:0]          guess;

    logic [WORD_LEN-1:0]          found;
    logic [25:0]                  guessed;
    logic [MISS_W-1:0]            misses;
    logic                         result_valid;
    logic                         last_hit;
    logic                         last_repeat;
    logic                         busy;
    logic                         win;
    logic                         lose;

    modport master (
        output start, word, word_len, go, guess,
        input  found, guessed, misses, result_valid, last_hit, last_repeat, busy, win, lose
    );

    modport slave (
        input  start, word, word_len, go, guess,
        output found, guessed, misses, result_valid, last_hit, last_repeat, busy, win, lose
    );
endinterface

// File: rtl/hangman_guess_engine.sv
// rtl/hangman_guess_engine.sv - hangman guess evaluator: per-position scan, alphabet/miss tracking, win/lose
module hangman_guess_engine #(
    parameter int WORD_LEN   = 5,
    parameter int LETTER_W   = 5,
    parameter int MAX_MISSES = 6,
    parameter int MISS_W     = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    hangman_guess_engine_if.slave   bus
);
    localparam int LEN_W = $clog2(WORD_LEN + 1);

    localparam logic [LEN_W-1:0]    WORD_LEN_C   = LEN_W'(WORD_LEN);
    localparam logic [LETTER_W-1:0] LETTER_LIM_C = LETTER_W'(26);
    localparam logic [MISS_W-1:0]   MISS_MAX_C   = MISS_W'(MAX_MISSES);

    typedef enum logic [2:0] {
        S_IDLE, S_READY, S_SCAN, S_RESULT, S_RELEASE, S_WIN, S_LOSE
    } state_t;

    state_t                       state;
    logic [WORD_LEN*LETTER_W-1:0] word_q;
    logic [LEN_W-1:0]             len_q;
    logic [LETTER_W-1:0]          guess_q;
    logic [LEN_W-1:0]             idx;
    logic                         hit_acc;
    logic                         rep;
    logic [WORD_LEN-1:0]          found_q;
    logic [25:0]                  guessed_q;
    logic [MISS_W-1:0]            misses_q;
    logic                         last_hit_q;
    logic                         last_repeat_q;

    logic [LETTER_W-1:0]          cur_letter;
    logic [WORD_LEN-1:0]          active_mask;
    logic [MISS_W-1:0]            misses_next;
    logic [LEN_W-1:0]             len_clamped;
    logic                         all_found;

    // Mux-style select keeps the scan index narrow instead of multiplying it up.
    always_comb begin
        cur_letter = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (idx == LEN_W'(i)) begin
                cur_letter = word_q[i*LETTER_W +: LETTER_W];
            end
        end
    end

    always_comb begin
        active_mask = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            active_mask[i] = (LEN_W'(i) < len_q);
        end
    end

    assign all_found   = ((found_q & active_mask) == active_mask);
    assign misses_next = (!hit_acc && !rep && (misses_q != MISS_MAX_C)) ? misses_q + MISS_W'(1) : misses_q;
    assign len_clamped = (bus.word_len > WORD_LEN_C) ? WORD_LEN_C : bus.word_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            word_q        <= '0;
            len_q         <= '0;
            guess_q       <= '0;
            idx           <= '0;
            hit_acc       <= 1'b0;
            rep           <= 1'b0;
            found_q       <= '0;
            guessed_q     <= '0;
            misses_q      <= '0;
            last_hit_q    <= 1'b0;
            last_repeat_q <= 1'b0;
        end else if (bus.start && (bus.word_len != '0)) begin
            // A new game always passes through S_RELEASE so a held go is not a guess.
            word_q        <= bus.word;
            len_q         <= len_clamped;
            found_q       <= '0;
            guessed_q     <= '0;
            misses_q      <= '0;
            last_hit_q    <= 1'b0;
            last_repeat_q <= 1'b0;
            state         <= S_RELEASE;
        end else begin
            case (state)
                S_READY: begin
                    if (bus.go) begin
                        guess_q <= bus.guess;
                        if (bus.guess >= LETTER_LIM_C) begin
                            state <= S_RELEASE;
                        end else if (guessed_q[bus.guess]) begin
                            hit_acc <= 1'b0;
                            rep     <= 1'b1;
                            state   <= S_RESULT;
                        end else begin
                            idx     <= '0;
                            hit_acc <= 1'b0;
                            rep     <= 1'b0;
                            state   <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (cur_letter == guess_q) begin
                        found_q[idx] <= 1'b1;
                        hit_acc      <= 1'b1;
                    end
                    if (idx == len_q - LEN_W'(1)) begin
                        state <= S_RESULT;
                    end else begin
                        idx <= idx + LEN_W'(1);
                    end
                end
                S_RESULT: begin
                    last_hit_q         <= hit_acc;
                    last_repeat_q      <= rep;
                    guessed_q[guess_q] <= 1'b1;
                    misses_q           <= misses_next;
                    if (all_found) begin
                        state <= S_WIN;
                    end else if (misses_next == MISS_MAX_C) begin
                        state <= S_LOSE;
                    end else begin
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!bus.go) begin
                        state <= S_READY;
                    end
                end
                default: begin
                    // S_IDLE, S_WIN and S_LOSE are left only by start or reset.
                end
            endcase
        end
    end

    assign bus.found        = found_q;
    assign bus.guessed      = guessed_q;
    assign bus.misses       = misses_q;
    assign bus.last_hit     = last_hit_q;
    assign bus.last_repeat  = last_repeat_q;
    assign bus.result_valid = (state == S_RESULT);
    assign bus.busy         = (state == S_SCAN) || (state == S_RESULT);
    assign bus.win          = (state == S_WIN);
    assign bus.lose         = (state == S_LOSE);
endmodule

// File: tb/tb_hangman_guess_engine.sv
// tb/tb_hangman_guess_engine.sv - scoreboard bench for hangman_guess_engine
module tb_hangman_guess_engine;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    hangman_guess_engine_if #(.WORD_LEN(5), .LETTER_W(5), .MISS_W(3)) bus ();

    hangman_guess_engine #(.WORD_LEN(5), .LETTER_W(5), .MAX_MISSES(6), .MISS_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        int          t0;
        int          lat;
        logic        hit;
        logic        rep;
        logic [4:0]  found;
        logic [25:0] guessed;
        logic [2:0]  misses;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    logic pend_valid = 1'b0;

    int          word_m[5];
    int          len_m;
    logic [4:0]  found_m;
    logic [25:0] guessed_m;
    int          misses_m;
    logic        over_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pend_valid) begin
            check("last_hit", 64'(bus.last_hit), 64'(pend.hit));
            check("last_repeat", 64'(bus.last_repeat), 64'(pend.rep));
            check("misses", 64'(bus.misses), 64'(pend.misses));
            check("guessed", 64'(bus.guessed), 64'(pend.guessed));
            pend_valid = 1'b0;
        end
        if (bus.result_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 64'd1, 64'd0);
            end else begin
                pend = sb.pop_front();
                check("latency", 64'(cyc - pend.t0), 64'(pend.lat));
                check("found_at_result", 64'(bus.found), 64'(pend.found));
                pend_valid = 1'b1;
            end
        end
    end

    task automatic start_game(input int w0, input int w1, input int w2, input int w3, input int w4, input int len);
        @(negedge clk);
        bus.word     = {5'(w4), 5'(w3), 5'(w2), 5'(w1), 5'(w0)};
        bus.word_len = 3'(len);
        bus.start    = 1'b1;
        word_m[0] = w0; word_m[1] = w1; word_m[2] = w2; word_m[3] = w3; word_m[4] = w4;
        len_m     = (len > 5) ? 5 : len;
        found_m   = '0;
        guessed_m = '0;
        misses_m  = 0;
        over_m    = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_guess(input int letter, input int hold);
        exp_t e;
        logic hit;
        @(negedge clk);
        if (!over_m && letter < 26) begin
            e.t0 = cyc;
            if (guessed_m[letter]) begin
                e.lat = 1;
                e.hit = 1'b0;
                e.rep = 1'b1;
            end else begin
                hit = 1'b0;
                for (int i = 0; i < len_m; i++) begin
                    if (word_m[i] == letter) begin
                        found_m[i] = 1'b1;
                        hit = 1'b1;
                    end
                end
                if (!hit && misses_m < 6) misses_m++;
                e.lat = len_m + 1;
                e.hit = hit;
                e.rep = 1'b0;
            end
            guessed_m[letter] = 1'b1;
            e.found   = found_m;
            e.guessed = guessed_m;
            e.misses  = 3'(misses_m);
            sb.push_back(e);
            if (((found_m | ~((5'b1 << len_m) - 5'b1)) == 5'b11111) || misses_m == 6) over_m = 1'b1;
        end
        bus.guess = 5'(letter);
        bus.go    = 1'b1;
        repeat (hold) @(negedge clk);
        bus.go = 1'b0;
        repeat (len_m + 4) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.found, bus.guessed, bus.misses, bus.result_valid, bus.last_hit,
                    bus.last_repeat, bus.busy, bus.win, bus.lose});
    endfunction

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.word     = '0;
        bus.word_len = '0;
        bus.go       = 1'b1;
        bus.guess    = '0;
        len_m        = 0;
        over_m       = 1'b0;

        // 1: reset state with go held
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        bus.go = 1'b0;
        reset  = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outputs", all_outs(), 64'd0);

        // 2: STAY, guess A
        start_game(18, 19, 0, 24, 31, 4);
        do_guess(0, 1);
        check("t2_found", 64'(bus.found), 64'b00100);
        check("t2_last_hit", 64'(bus.last_hit), 64'd1);
        check("t2_misses", 64'(bus.misses), 64'd0);
        check("t2_guessed_a", 64'(bus.guessed[0]), 64'd1);

        // 3: held miss, then invalid code
        do_guess(16, 20);
        check("t3_misses", 64'(bus.misses), 64'd1);
        check("t3_last_hit", 64'(bus.last_hit), 64'd0);
        do_guess(31, 1);
        check("t3_inv_misses", 64'(bus.misses), 64'd1);

        // 4: repeat
        do_guess(0, 1);
        check("t4_repeat", 64'(bus.last_repeat), 64'd1);
        check("t4_misses", 64'(bus.misses), 64'd1);
        check("t4_found", 64'(bus.found), 64'b00100);

        // 5: win, filler position stays dark
        do_guess(18, 1);
        do_guess(19, 1);
        do_guess(24, 1);
        check("t5_found", 64'(bus.found), 64'b01111);
        check("t5_win", 64'(bus.win), 64'd1);
        do_guess(1, 1);
        check("t5_win_hold", 64'(bus.win), 64'd1);
        start_game(18, 19, 0, 24, 31, 4);
        check("t5_restart", all_outs(), 64'd0);

        // 6: lose with six distinct misses
        for (int l = 1; l <= 6; l++) do_guess(l, 1);
        check("t6_misses", 64'(bus.misses), 64'd6);
        check("t6_lose", 64'(bus.lose), 64'd1);
        check("t6_no_win", 64'(bus.win), 64'd0);

        // 6b: reset in second scan cycle
        start_game(2, 7, 11, 4, 31, 4);
        @(negedge clk);
        bus.guess = 5'd2;
        bus.go    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t6_busy_scan", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        #1;
        check("t6_async_reset", all_outs(), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_idle_after_reset", all_outs(), 64'd0);
        bus.go = 1'b0;
        repeat (2) @(negedge clk);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
